// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum stage is selected by LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } loader_state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;

    // States in which the loader consumes stream bytes
    function automatic logic rx_state(input loader_state_e st);
        return (st == LEN_HI) || (st == LEN_LO) || (st == DATA) || (st == CHK);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted stream bytes (MSB first) into 32-bit words; the completed
// word and its one-cycle valid pulse appear the cycle after the 4th byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        last_byte
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shift_r;
    logic [1:0]  cnt_r;
    logic [31:0] word_r;
    logic        word_valid_r;

    assign word       = word_r;
    assign word_valid = word_valid_r;
    assign last_byte  = (cnt_r == LAST_IDX);

    // Byte shift register, wrapping byte counter and completed-word capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r      <= 24'd0;
            cnt_r        <= 2'd0;
            word_r       <= 32'd0;
            word_valid_r <= 1'b0;
        end else if (clear) begin
            cnt_r        <= 2'd0;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= byte_valid && (cnt_r == LAST_IDX);
            if (byte_valid) begin
                shift_r <= {shift_r[15:0], byte_data};
                cnt_r   <= cnt_r + 2'd1;
                if (cnt_r == LAST_IDX) begin
                    word_r <= {shift_r, byte_data};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length-prefixed byte stream in, word writes out.
// Define LOADER_CHECKSUM_EN to append and verify an XOR checksum byte.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rxData,
    input  logic              rxValid,
    output logic              rxReady,
    output logic              imemWriteEn,
    output logic [ADDR_W-1:0] imemWriteAddr,
    output logic [31:0]       imemWriteData,
    output logic              cpuRst,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

    loader_state_e state_r, next_state_s;

    logic [7:0]  len_hi_r;
    logic [15:0] len_r;
    logic [15:0] word_cnt_r;
    logic [15:0] len_full_s;
    logic        accept_s;
    logic        start_ok_s;
    logic        data_byte_s;
    logic        last_byte_s;
    logic        word_end_s;
    logic        last_word_s;

    assign accept_s    = rxValid && rxReady;
    assign start_ok_s  = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERROR));
    assign data_byte_s = accept_s && (state_r == DATA);
    assign word_end_s  = data_byte_s && last_byte_s;
    assign last_word_s = word_end_s && ((word_cnt_r + 16'd1) == len_r);
    assign len_full_s  = {len_hi_r, rxData};

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] chk_r;

    // Running XOR over data bytes only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_r <= 8'd0;
        end else if (start_ok_s) begin
            chk_r <= 8'd0;
        end else if (data_byte_s) begin
            chk_r <= chk_r ^ rxData;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    next_state_s = LEN_HI;
                end else begin
                    next_state_s = state_r;
                end
            end
            LEN_HI: begin
                if (accept_s) begin
                    next_state_s = LEN_LO;
                end else begin
                    next_state_s = LEN_HI;
                end
            end
            LEN_LO: begin
                if (!accept_s) begin
                    next_state_s = LEN_LO;
                end else if (len_full_s == 16'd0) begin
                    next_state_s = DONE;
                end else if ({1'b0, len_full_s} > MAX_WORDS) begin
                    next_state_s = ERROR;
                end else begin
                    next_state_s = DATA;
                end
            end
            DATA: begin
                if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                    next_state_s = CHK;
`else
                    next_state_s = DONE;
`endif
                end else begin
                    next_state_s = DATA;
                end
            end
            CHK: begin
`ifdef LOADER_CHECKSUM_EN
                if (!accept_s) begin
                    next_state_s = CHK;
                end else if (rxData == chk_r) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = ERROR;
                end
`else
                next_state_s = ERROR;
`endif
            end
            default: next_state_s = ERROR;
        endcase
    end

    // Status outputs registered from the next state so they track state_r exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxReady <= 1'b0;
            cpuRst  <= 1'b1;
            done    <= 1'b0;
            error   <= 1'b0;
        end else begin
            rxReady <= rx_state(next_state_s);
            cpuRst  <= (next_state_s != DONE);
            done    <= (next_state_s == DONE);
            error   <= (next_state_s == ERROR);
        end
    end

    // Length capture, word index and write address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_hi_r      <= 8'd0;
            len_r         <= 16'd0;
            word_cnt_r    <= 16'd0;
            imemWriteAddr <= '0;
        end else begin
            if (accept_s && (state_r == LEN_HI)) begin
                len_hi_r <= rxData;
            end
            if (accept_s && (state_r == LEN_LO)) begin
                len_r <= len_full_s;
            end
            if (start_ok_s) begin
                word_cnt_r <= 16'd0;
            end else if (word_end_s) begin
                word_cnt_r    <= word_cnt_r + 16'd1;
                imemWriteAddr <= word_cnt_r[ADDR_W-1:0];
            end
        end
    end

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok_s),
        .byte_valid (data_byte_s),
        .byte_data  (rxData),
        .word       (imemWriteData),
        .word_valid (imemWriteEn),
        .last_byte  (last_byte_s)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: length-field vector table, directed
// frames, reset corner cases and randomized frames against a word-list model.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        rxData;
    logic              rxValid;
    logic              rxReady;
    logic              imemWriteEn;
    logic [ADDR_W-1:0] imemWriteAddr;
    logic [31:0]       imemWriteData;
    logic              cpuRst;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t got_q[$];

    typedef struct {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       exp_done;
        logic       exp_error;
        logic       exp_ready;
    } len_vec_t;
    len_vec_t vecs[6];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .rxData        (rxData),
        .rxValid       (rxValid),
        .rxReady       (rxReady),
        .imemWriteEn   (imemWriteEn),
        .imemWriteAddr (imemWriteAddr),
        .imemWriteData (imemWriteData),
        .cpuRst        (cpuRst),
        .done          (done),
        .error         (error)
    );

    always #5 clk = ~clk;

    // Capture every write strobe seen between clock edges
    always @(negedge clk) begin
        if (imemWriteEn === 1'b1) begin
            got_q.push_back('{addr: imemWriteAddr, data: imemWriteData});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        rxValid = 1'b0;
        start   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte until accepted; optional random idle cycles with garbage data
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                rxValid = 1'b0;
                rxData  = 8'($urandom);
            end else begin
                rxValid = 1'b1;
                rxData  = b;
            end
            acc = rxValid && rxReady;
            guard++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    // Load a full frame and compare writes against the word list
    task automatic run_frame(input logic [31:0] words[$], input bit gaps);
        int n;
        n = words.size();
        got_q.delete();
        pulse_start();
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                send_byte(words[i][8*k +: 8], gaps);
            end
        end
        @(negedge clk);
        rxValid = 1'b0;
        chk("done_same_cycle", {31'd0, done}, 32'd1);
        chk("cpurst_released", {31'd0, cpuRst}, 32'd0);
        repeat (3) @(negedge clk);
        chk("write_count", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            if (got_q[i].addr !== ADDR_W'(i) || got_q[i].data !== words[i]) begin
                chk("write_addr", {24'd0, got_q[i].addr}, i);
                chk("write_data", got_q[i].data, words[i]);
            end else begin
                n_checks++;
                n_pass++;
            end
        end
        chk("frame_done", {31'd0, done}, 32'd1);
        chk("frame_error", {31'd0, error}, 32'd0);
        chk("frame_ready", {31'd0, rxReady}, 32'd0);
    endtask

    initial begin
        logic [31:0] words[$];
        rst     = 1'b1;
        start   = 1'b0;
        rxValid = 1'b0;
        rxData  = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, rxReady}, 32'd0);
        chk("rst_cpurst", {31'd0, cpuRst}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_we", {31'd0, imemWriteEn}, 32'd0);
        rst = 1'b0;

        // Length-field outcomes
        vecs[0] = '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 8'h05, 1'b0, 1'b0, 1'b1};
        for (int v = 0; v < 6; v++) begin
            got_q.delete();
            pulse_start();
            send_byte(vecs[v].hi, 1'b0);
            send_byte(vecs[v].lo, 1'b0);
            @(negedge clk);
            rxValid = 1'b0;
            chk($sformatf("len%0d_done", v), {31'd0, done}, {31'd0, vecs[v].exp_done});
            chk($sformatf("len%0d_error", v), {31'd0, error}, {31'd0, vecs[v].exp_error});
            chk($sformatf("len%0d_ready", v), {31'd0, rxReady}, {31'd0, vecs[v].exp_ready});
            chk($sformatf("len%0d_cpurst", v), {31'd0, cpuRst}, {31'd0, !vecs[v].exp_done});
            repeat (2) @(negedge clk);
            chk($sformatf("len%0d_nowrite", v), got_q.size(), 32'd0);
            if (vecs[v].exp_done || vecs[v].exp_error) begin
                pulse_start();
                chk($sformatf("len%0d_restart_ready", v), {31'd0, rxReady}, 32'd1);
                chk($sformatf("len%0d_restart_flags", v), {30'd0, done, error}, 32'd0);
            end
            do_reset();
        end

        // Two-word frame, back-to-back then with gaps
        words = '{32'h12345678, 32'h9ABCDEF0};
        run_frame(words, 1'b0);
        run_frame(words, 1'b1);

        // Asynchronous reset between clock edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_ready", {31'd0, rxReady}, 32'd0);
        chk("async_cpurst", {31'd0, cpuRst}, 32'd1);
        chk("async_done", {31'd0, done}, 32'd0);
        chk("async_addr", {24'd0, imemWriteAddr}, 32'd0);
        chk("async_data", imemWriteData, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset after two data bytes discards the partial word
        got_q.delete();
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        @(negedge clk);
        rxValid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, rxReady}, 32'd0);
        chk("midrst_cpurst", {31'd0, cpuRst}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_nowrite", got_q.size(), 32'd0);
        chk("midrst_idle_ready", {31'd0, rxReady}, 32'd0);

        // Maximum image: every address written once
        words.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) words.push_back($urandom);
        run_frame(words, 1'b0);
        chk("max_last_addr", {24'd0, got_q[got_q.size()-1].addr}, 32'h0000_00FF);

        // Random frames with random valid gaps
        for (int t = 0; t < 12; t++) begin
            words.delete();
            for (int i = 0; i < $urandom_range(1, 9); i++) words.push_back($urandom);
            run_frame(words, ($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
